// File: rtl/mpw4_readout_pkg.sv
// Shared readout definitions: default word/FIFO geometry and the serializer state encoding.
package mpw4_readout_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int DEPTH_DEF  = 16;

  // Two-bit encoding leaves spare codes; the FSM folds them back into IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } ser_state_e;

endpackage

// File: rtl/tx_fifo_sync.sv
// Single-clock word FIFO with registered full/empty/level and a registered,
// show-ahead read port (head word always valid one cycle after it is written).
module tx_fifo_sync
  import mpw4_readout_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_req_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              wr_en, rd_en;

  always_comb begin
    wr_en    = wr_req_i & ~full_q & ~srst;
    rd_en    = rd_en_i & ~empty_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    level_d  = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
    full_d   = (level_d == LVL_W'(DEPTH));
    empty_d  = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Read address runs one pointer ahead; a write landing on that slot is forwarded.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
    if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
      rd_data_q <= wr_data_i;
    end else begin
      rd_data_q <= mem[rd_ptr_d];
    end
  end

  assign rd_data_o = rd_data_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;

endmodule

// File: rtl/tx_serializer.sv
// EOC hit-word serializer: buffers words in tx_fifo_sync and shifts them out MSB first
// with registered data/valid/start-of-frame outputs and a saturating drop counter.
module tx_serializer
  import mpw4_readout_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                    clk40MHz_i,
  input  logic                    rst_i,
  input  logic [DATA_W-1:0]       eoc_data_i,
  input  logic                    tx_fifo_wr_n_i,
  output logic                    tx_fifo_full_o,
  input  logic                    ser_en_i,
  output logic                    ser_data_o,
  output logic                    ser_valid_o,
  output logic                    ser_sof_o,
  output logic [7:0]              ovf_cnt_o,
  output logic [$clog2(DEPTH):0]  fifo_level_o
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  ser_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ser_data_q, ser_data_d;
  logic              ser_valid_q, ser_valid_d;
  logic              ser_sof_q, ser_sof_d;
  logic [7:0]        ovf_q, ovf_d;

  logic              wr_req;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign wr_req = ~tx_fifo_wr_n_i;

  tx_fifo_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk40MHz_i),
    .srst      (rst_i),
    .wr_req_i  (wr_req),
    .wr_data_i (eoc_data_i),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level_o)
  );

  // A write while full is lost even if a pop frees a slot on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_req && fifo_full && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    fifo_pop    = 1'b0;
    ser_data_d  = 1'b0;
    ser_valid_d = 1'b0;
    ser_sof_d   = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        ser_data_d  = shift_q[DATA_W-1];
        ser_valid_d = 1'b1;
        ser_sof_d   = (bit_cnt_q == CNT_LAST);
        shift_d     = shift_q << 1;
        bit_cnt_d   = bit_cnt_q - CNT_W'(1);
        if (bit_cnt_q == '0) begin
          if (!fifo_empty && ser_en_i) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_head;
            bit_cnt_d = CNT_LAST;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (!fifo_empty && ser_en_i) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_head;
          bit_cnt_d = CNT_LAST;
          state_d   = ST_SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clk40MHz_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ser_data_q  <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_sof_q   <= 1'b0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
      ser_sof_q   <= ser_sof_d;
      ovf_q       <= ovf_d;
    end
  end

  assign tx_fifo_full_o = fifo_full;
  assign ser_data_o     = ser_data_q;
  assign ser_valid_o    = ser_valid_q;
  assign ser_sof_o      = ser_sof_q;
  assign ovf_cnt_o      = ovf_q;

endmodule

// File: tb/tb_tx_serializer.sv
// Directed and randomized checks of tx_serializer against a queue-based model of
// the FIFO contents and drop counter, with a monitor that reassembles serial words.
module tb_tx_serializer;

  localparam int DW    = 24;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] eoc_data;
  logic          wr_n;
  logic          full;
  logic          ser_en;
  logic          ser_data;
  logic          ser_valid;
  logic          ser_sof;
  logic [7:0]    ovf_cnt;
  logic [4:0]    fifo_level;

  always #12 clk = ~clk;

  tx_serializer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk40MHz_i     (clk),
    .rst_i          (rst),
    .eoc_data_i     (eoc_data),
    .tx_fifo_wr_n_i (wr_n),
    .tx_fifo_full_o (full),
    .ser_en_i       (ser_en),
    .ser_data_o     (ser_data),
    .ser_valid_o    (ser_valid),
    .ser_sof_o      (ser_sof),
    .ovf_cnt_o      (ovf_cnt),
    .fifo_level_o   (fifo_level)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] model_q[$];
  int            ovf_m = 0;

  logic [DW-1:0] rx_q[$];
  int            proto_err = 0;
  logic [DW-1:0] mon_cur;
  int            mon_bits = 0;
  logic          mon_in_word = 1'b0;

  // Reassembles words from the serial stream; any malformed framing is tallied.
  always @(negedge clk) begin
    if (rst) begin
      mon_in_word = 1'b0;
      mon_bits    = 0;
    end else if (ser_valid) begin
      if (ser_sof) begin
        if (mon_in_word) proto_err++;
        mon_in_word = 1'b1;
        mon_bits    = 0;
        mon_cur     = '0;
      end else if (!mon_in_word) begin
        proto_err++;
      end
      mon_cur  = {mon_cur[DW-2:0], ser_data};
      mon_bits = mon_bits + 1;
      if (mon_bits == DW) begin
        rx_q.push_back(mon_cur);
        $display("[TB] rx word %06h", mon_cur);
        mon_in_word = 1'b0;
        mon_bits    = 0;
      end
    end else begin
      if (mon_in_word) proto_err++;
      mon_in_word = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input logic [DW-1:0] w);
    if (model_q.size() < DEPTH) model_q.push_back(w);
    else if (ovf_m < 255) ovf_m++;
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    wr_n     = 1'b0;
    eoc_data = w;
    tick();
    wr_n     = 1'b1;
    $display("[TB] write %06h level=%0d full=%0b ovf=%0d", w, fifo_level, full, ovf_cnt);
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, (rx_q.size() >= n), 1);
  endtask

  task automatic wait_sof(input string tag);
    for (int k = 0; k < 10 && !ser_sof; k++) tick();
    check(tag, ser_sof, 1);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] wq[3];
    logic [47:0]   stream;
    int            seen;

    rst = 1'b1; wr_n = 1'b1; eoc_data = '0; ser_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_valid", ser_valid, 0);
    check("rst_sof",   ser_sof, 0);
    check("rst_data",  ser_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_full",  full, 0);
    check("rst_ovf",   ovf_cnt, 0);

    // Single word: MSB two edges after the write, exactly DW valid cycles.
    ser_en = 1'b1;
    rx_q.delete();
    w = 24'hA5C3F0;
    write_word(w);
    check("single_lat_n", ser_valid, 0);
    tick();
    check("single_lat_n1", ser_valid, 0);
    tick();
    for (int i = 0; i < DW; i++) begin
      check("single_data",  ser_data, w[DW-1-i]);
      check("single_valid", ser_valid, 1);
      check("single_sof",   ser_sof, (i == 0));
      tick();
    end
    check("single_end_valid", ser_valid, 0);
    check("single_end_level", fifo_level, 0);
    check("single_rx_cnt", rx_q.size(), 1);
    check("single_rx_word", rx_q[0], w);

    // Back-to-back words with no gap.
    repeat (3) tick();
    stream = {24'h000001, 24'hFFFFFF};
    wr_n = 1'b0; eoc_data = 24'h000001; tick();
    eoc_data = 24'hFFFFFF; tick();
    wr_n = 1'b1;
    tick();
    for (int i = 0; i < 2 * DW; i++) begin
      check("b2b_valid", ser_valid, 1);
      check("b2b_sof",   ser_sof, (i == 0 || i == DW));
      check("b2b_data",  ser_data, stream[2*DW-1-i]);
      tick();
    end
    check("b2b_end_valid", ser_valid, 0);

    // Overflow with the link disabled.
    repeat (3) tick();
    ser_en = 1'b0;
    model_q.delete();
    rx_q.delete();
    for (int i = 0; i < 20; i++) begin
      w = DW'($urandom);
      write_word(w);
      push_model(w);
    end
    check("ovf_level", fifo_level, model_q.size());
    check("ovf_full",  full, 1);
    check("ovf_cnt",   ovf_cnt, ovf_m);
    check("ovf_cnt4",  ovf_cnt, 4);
    // Pop and write on the same edge while full: write is still dropped.
    ser_en = 1'b1;
    write_word(DW'($urandom));
    if (ovf_m < 255) ovf_m++;
    check("popdrop_level", fifo_level, 15);
    check("popdrop_full",  full, 0);
    check("popdrop_ovf",   ovf_cnt, ovf_m);
    wait_rx(DEPTH, DEPTH * DW + 50, "ovf_drain_timeout");
    for (int i = 0; i < DEPTH; i++) check("ovf_order", rx_q[i], model_q[i]);
    repeat (3) tick();
    check("ovf_drain_level", fifo_level, 0);

    // Saturation of the drop counter.
    ser_en = 1'b0;
    model_q.delete();
    for (int i = 0; i < DEPTH + 300; i++) begin
      wr_n = 1'b0; eoc_data = DW'($urandom); tick();
      push_model(eoc_data);
    end
    wr_n = 1'b1;
    $display("[TB] saturation writes done ovf=%0d", ovf_cnt);
    check("sat_ovf",   ovf_cnt, ovf_m);
    check("sat_255",   ovf_cnt, 255);
    check("sat_level", fifo_level, DEPTH);

    // Reset mid-word with three words queued.
    rst = 1'b1; tick(); rst = 1'b0;
    ovf_m = 0;
    check("rst2_ovf",   ovf_cnt, 0);
    check("rst2_level", fifo_level, 0);
    rx_q.delete();
    for (int i = 0; i < 3; i++) write_word(DW'($urandom));
    check("midrst_level3", fifo_level, 3);
    ser_en = 1'b1;
    wait_sof("midrst_sof_timeout");
    repeat (10) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_valid", ser_valid, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_full",  full, 0);
    check("midrst_sof",   ser_sof, 0);
    check("midrst_data",  ser_data, 0);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      seen += int'(ser_valid);
      tick();
    end
    check("midrst_quiet", seen, 0);
    check("midrst_rx", rx_q.size(), 0);
    w = DW'($urandom);
    write_word(w);
    wait_rx(1, 60, "midrst_new_timeout");
    check("midrst_new_word", rx_q[0], w);

    // Enable dropped mid-word: current word completes, nothing else starts.
    repeat (3) tick();
    ser_en = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 3; i++) begin
      wq[i] = DW'($urandom);
      write_word(wq[i]);
    end
    ser_en = 1'b1;
    wait_sof("endrop_sof_timeout");
    check("endrop_level_start", fifo_level, 2);
    repeat (5) tick();
    ser_en = 1'b0;
    seen = 0;
    for (int i = 5; i < DW; i++) begin
      seen += int'(ser_valid);
      tick();
    end
    check("endrop_tail_valid", seen, DW - 5);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      seen += int'(ser_valid);
      tick();
    end
    check("endrop_idle", seen, 0);
    check("endrop_level", fifo_level, 2);
    check("endrop_rx_cnt", rx_q.size(), 1);
    check("endrop_word", rx_q[0], wq[0]);
    ser_en = 1'b1;
    wait_rx(3, 3 * DW + 20, "endrop_drain_timeout");
    check("endrop_word1", rx_q[1], wq[1]);
    check("endrop_word2", rx_q[2], wq[2]);

    // Randomized rounds: random writes with the link off, then a stuttering drain.
    for (int r = 0; r < 6; r++) begin
      int n;
      int k;
      repeat (3) tick();
      ser_en = 1'b0;
      repeat (DW + 2) tick();
      rx_q.delete();
      model_q.delete();
      n = $urandom_range(5, 26);
      for (int i = 0; i < n; i++) begin
        wr_n     = ($urandom_range(0, 9) < 7) ? 1'b0 : 1'b1;
        eoc_data = DW'($urandom);
        tick();
        if (!wr_n) push_model(eoc_data);
      end
      wr_n = 1'b1;
      $display("[TB] round %0d: %0d queued ovf_model=%0d", r, model_q.size(), ovf_m);
      check("rnd_level", fifo_level, model_q.size());
      check("rnd_full",  full, (model_q.size() == DEPTH));
      check("rnd_ovf",   ovf_cnt, ovf_m);
      k = 0;
      while (rx_q.size() < model_q.size() && k < 4000) begin
        ser_en = ($urandom_range(0, 3) != 0);
        tick();
        k++;
      end
      ser_en = 1'b0;
      check("rnd_rx_cnt", rx_q.size(), model_q.size());
      for (int i = 0; i < model_q.size() && i < rx_q.size(); i++)
        check("rnd_word", rx_q[i], model_q[i]);
      repeat (3) tick();
      check("rnd_end_level", fifo_level, 0);
    end

    check("framing_errors", proto_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
